// File: rtl/heap_xbar_arb.sv
// rtl/heap_xbar_arb.sv - CHANS x BANKS arbitrated heap crossbar with tagged read-data return
// Optional macro HEAP_XBAR_RSP_REG_EN registers the read-response outputs.
module heap_xbar_arb #(
  parameter int CHANS  = 4,
  parameter int BANKS  = 16,
  parameter int DATA_W = 7,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic [CHANS-1:0]                          i_req_valid,
  input  logic [CHANS-1:0]                          i_req_we,
  input  logic [CHANS*ADDR_W-1:0]                   i_req_addr,
  input  logic [CHANS*DATA_W-1:0]                   i_req_data,
  output logic [CHANS-1:0]                          o_req_ready,
  output logic [BANKS-1:0]                          o_bank_en,
  output logic [BANKS-1:0]                          o_bank_we,
  output logic [BANKS*(ADDR_W-$clog2(BANKS))-1:0]   o_bank_addr,
  output logic [BANKS*DATA_W-1:0]                   o_bank_wdata,
  input  logic [BANKS*DATA_W-1:0]                   i_bank_rdata,
  output logic [CHANS-1:0]                          o_rsp_valid,
  output logic [CHANS*DATA_W-1:0]                   o_rsp_data
);
  localparam int BANK_W  = $clog2(BANKS);
  localparam int LADDR_W = ADDR_W - BANK_W;
  localparam int CHAN_W  = (CHANS > 1) ? $clog2(CHANS) : 1;
  localparam int TAG_W   = CHAN_W + 1;

  logic [CHAN_W-1:0]  ptr_q     [BANKS];
  logic [CHAN_W-1:0]  ptr_d     [BANKS];
  logic [CHAN_W-1:0]  gnt_idx   [BANKS];
  logic [BANKS-1:0]   bank_gnt;
  logic [CHANS-1:0]   gnt;

  logic [BANKS-1:0]   en_q;
  logic [BANKS-1:0]   we_q;
  logic [LADDR_W-1:0] addr_q    [BANKS];
  logic [DATA_W-1:0]  wdata_q   [BANKS];
  logic [CHAN_W-1:0]  chan_q    [BANKS];
  logic [TAG_W-1:0]   tag_q     [BANKS][RD_LAT];

  logic [CHANS-1:0]        rsp_valid_d;
  logic [CHANS*DATA_W-1:0] rsp_data_d;

  // Per-bank round-robin: scan channels starting at the pointer, first match wins.
  always_comb begin : arb
    int idx;
    idx = 0;
    gnt = '0;
    for (int b = 0; b < BANKS; b++) begin
      bank_gnt[b] = 1'b0;
      gnt_idx[b]  = '0;
      ptr_d[b]    = ptr_q[b];
      for (int k = 0; k < CHANS; k++) begin
        idx = int'(ptr_q[b]) + k;
        if (idx >= CHANS) idx = idx - CHANS;
        if (!bank_gnt[b] && i_req_valid[idx] &&
            (i_req_addr[idx*ADDR_W +: BANK_W] == BANK_W'(b))) begin
          bank_gnt[b] = 1'b1;
          gnt_idx[b]  = CHAN_W'(idx);
        end
      end
      if (bank_gnt[b]) begin
        gnt[gnt_idx[b]] = 1'b1;
        ptr_d[b] = (gnt_idx[b] == CHAN_W'(CHANS-1)) ? '0 : gnt_idx[b] + 1'b1;
      end
    end
  end

  assign o_req_ready = i_rst_n ? gnt : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q <= '0;
      we_q <= '0;
      for (int b = 0; b < BANKS; b++) begin
        ptr_q[b]   <= '0;
        addr_q[b]  <= '0;
        wdata_q[b] <= '0;
        chan_q[b]  <= '0;
        for (int k = 0; k < RD_LAT; k++) tag_q[b][k] <= '0;
      end
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        ptr_q[b] <= ptr_d[b];
        en_q[b]  <= bank_gnt[b];
        if (bank_gnt[b]) begin
          we_q[b]    <= i_req_we[gnt_idx[b]];
          addr_q[b]  <= i_req_addr[int'(gnt_idx[b])*ADDR_W + BANK_W +: LADDR_W];
          wdata_q[b] <= i_req_data[int'(gnt_idx[b])*DATA_W +: DATA_W];
          chan_q[b]  <= gnt_idx[b];
        end
        // The tag enters alongside the bank strobe so its tail lines up with rdata.
        tag_q[b][0] <= {en_q[b] & ~we_q[b], chan_q[b]};
        for (int k = 1; k < RD_LAT; k++) tag_q[b][k] <= tag_q[b][k-1];
      end
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (tag_q[b][RD_LAT-1][CHAN_W]) begin
        rsp_valid_d[tag_q[b][RD_LAT-1][CHAN_W-1:0]] = 1'b1;
        rsp_data_d[int'(tag_q[b][RD_LAT-1][CHAN_W-1:0])*DATA_W +: DATA_W] =
          rsp_data_d[int'(tag_q[b][RD_LAT-1][CHAN_W-1:0])*DATA_W +: DATA_W] |
          i_bank_rdata[b*DATA_W +: DATA_W];
      end
    end
  end

`ifdef HEAP_XBAR_RSP_REG_EN
  logic [CHANS-1:0]        rsp_valid_q;
  logic [CHANS*DATA_W-1:0] rsp_data_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
`else
  assign o_rsp_valid = rsp_valid_d;
  assign o_rsp_data  = rsp_data_d;
`endif

  assign o_bank_en = en_q;
  assign o_bank_we = we_q;
  for (genvar b = 0; b < BANKS; b++) begin : g_bank_out
    assign o_bank_addr[b*LADDR_W +: LADDR_W] = addr_q[b];
    assign o_bank_wdata[b*DATA_W +: DATA_W]  = wdata_q[b];
  end
endmodule

// File: tb/tb_heap_xbar_arb.sv
// tb/tb_heap_xbar_arb.sv - directed scoreboard bench for heap_xbar_arb with a one-cycle bank RAM model
module tb_heap_xbar_arb;
  localparam int RSP_DLY =
`ifdef HEAP_XBAR_RSP_REG_EN
    2;
`else
    1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req_valid = '0;
  logic [3:0]    req_we = '0;
  logic [35:0]   req_addr = '0;
  logic [27:0]   req_data = '0;
  logic [3:0]    req_ready;
  logic [15:0]   bank_en;
  logic [15:0]   bank_we;
  logic [79:0]   bank_addr;
  logic [111:0]  bank_wdata;
  logic [111:0]  bank_rdata = '0;
  logic [3:0]    rsp_valid;
  logic [27:0]   rsp_data;

  int vectors = 0;
  int miscompares = 0;
  logic [6:0] exp_q [4][$];
  logic [6:0] mem [16][32];
  logic       loaded = 1'b0;

  heap_xbar_arb dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr), .i_req_data(req_data),
    .o_req_ready(req_ready),
    .o_bank_en(bank_en), .o_bank_we(bank_we), .o_bank_addr(bank_addr), .o_bank_wdata(bank_wdata),
    .i_bank_rdata(bank_rdata),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] init_val(int b, int a);
    if (b == 3 && a == 2) return 7'h55;
    if (b == 5 && a >= 1 && a <= 4) return 7'(7'h10 + a - 1);
    if (b <= 3 && a == 1) return 7'(7'h20 + b);
    if (b == 7 && a == 2) return 7'h62;
    if (b == 7 && a == 4) return 7'h44;
    if (b == 9 && a == 2) return 7'h19;
    return 7'h00;
  endfunction

  // Bank RAM model: read data valid one cycle after the strobe.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int b = 0; b < 16; b++)
        for (int a = 0; a < 32; a++) mem[b][a] <= init_val(b, a);
      loaded <= 1'b1;
    end else begin
      for (int b = 0; b < 16; b++) begin
        if (bank_en[b]) begin
          if (bank_we[b]) mem[b][bank_addr[b*5 +: 5]] <= bank_wdata[b*7 +: 7];
          else bank_rdata[b*7 +: 7] <= mem[b][bank_addr[b*5 +: 5]];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid[c] === 1'b1) begin
        if (exp_q[c].size() == 0) chk($sformatf("unexpected_rsp_ch%0d", c), 32'(rsp_valid[c]), 32'd0);
        else chk($sformatf("rsp_data_ch%0d", c), 32'(rsp_data[c*7 +: 7]), 32'(exp_q[c].pop_front()));
      end else begin
        chk($sformatf("idle_rsp_data_ch%0d", c), 32'(rsp_data[c*7 +: 7]), 32'd0);
      end
    end
  end

  task automatic drive(input int c, input logic v, input logic we, input logic [8:0] a, input logic [6:0] d);
    req_valid[c] = v;
    req_we[c] = we;
    req_addr[c*9 +: 9] = a;
    req_data[c*7 +: 7] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    for (int c = 0; c < 4; c++) drive(c, 1'b0, 1'b0, 9'h000, 7'h00);
  endtask

  task automatic reset_pulse();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};

    // Reset state, with requests pending to prove ready is gated.
    for (int c = 0; c < 4; c++) drive(c, 1'b1, 1'b0, 9'h000, 7'h00);
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_bank_en", 32'(bank_en), 32'd0);
    chk("reset_bank_we", 32'(bank_we), 32'd0);
    chk("reset_bank_addr", 32'(|bank_addr), 32'd0);
    chk("reset_bank_wdata", 32'(|bank_wdata), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    drop_all();
    step();
    rst_n = 1'b1;

    // Single read: ch0 addr 0x023 -> bank 3 local 2, data 0x55.
    step();
    drive(0, 1'b1, 1'b0, 9'h023, 7'h00);
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h1);
    exp_q[0].push_back(7'h55);
    step();
    drop_all();
    @(negedge clk);
    chk("single_bank_en", 32'(bank_en), 32'h0008);
    chk("single_bank_addr", 32'(bank_addr[3*5 +: 5]), 32'h02);
    chk("single_bank_we", 32'(bank_we[3]), 32'd0);
    repeat (RSP_DLY) @(negedge clk);
    chk("single_rsp_timing", 32'(rsp_valid), 32'h1);

    // Conflict: all channels read bank 5 from reset; expect grants 0,1,2,3,0.
    reset_pulse();
    for (int c = 0; c < 4; c++) drive(c, 1'b1, 1'b0, 9'(((c + 1) << 4) | 5), 7'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("conflict_grant_%0d", i), 32'(req_ready), 32'(1 << order[i]));
      chk($sformatf("conflict_onehot_%0d", i), 32'($countones(req_ready)), 32'd1);
      exp_q[order[i]].push_back(7'(7'h10 + order[i]));
      step();
    end
    drop_all();

    // Parallel, no conflict: ch c -> bank c, local 1.
    step();
    for (int c = 0; c < 4; c++) drive(c, 1'b1, 1'b0, 9'((1 << 4) | c), 7'h00);
    @(negedge clk);
    chk("parallel_ready", 32'(req_ready), 32'hF);
    for (int c = 0; c < 4; c++) exp_q[c].push_back(7'(7'h20 + c));
    step();
    drop_all();
    @(negedge clk);
    chk("parallel_bank_en", 32'(bank_en), 32'h000F);

    // Write then read: ch1 writes 0x2A to 0x104 (bank 4, local 0x10), ch2 reads it back.
    step();
    drive(1, 1'b1, 1'b1, 9'h104, 7'h2A);
    @(negedge clk);
    chk("write_ready", 32'(req_ready), 32'h2);
    step();
    drop_all();
    @(negedge clk);
    chk("write_bank_en", 32'(bank_en), 32'h0010);
    chk("write_bank_we", 32'(bank_we[4]), 32'd1);
    chk("write_bank_wdata", 32'(bank_wdata[4*7 +: 7]), 32'h2A);
    chk("write_bank_addr", 32'(bank_addr[4*5 +: 5]), 32'h10);
    step();
    drive(2, 1'b1, 1'b0, 9'h104, 7'h00);
    @(negedge clk);
    chk("readback_ready", 32'(req_ready), 32'h4);
    exp_q[2].push_back(7'h2A);
    step();
    drop_all();

    // Mixed contention on bank 7: move pointer to 3, then ch0 write vs ch3 read.
    step();
    drive(2, 1'b1, 1'b0, 9'h027, 7'h00);
    @(negedge clk);
    chk("mixed_setup_ready", 32'(req_ready), 32'h4);
    exp_q[2].push_back(7'h62);
    step();
    drive(2, 1'b0, 1'b0, 9'h000, 7'h00);
    drive(0, 1'b1, 1'b1, 9'h037, 7'h33);
    drive(3, 1'b1, 1'b0, 9'h047, 7'h00);
    @(negedge clk);
    chk("mixed_first_ch3", 32'(req_ready), 32'h8);
    exp_q[3].push_back(7'h44);
    step();
    drive(3, 1'b0, 1'b0, 9'h000, 7'h00);
    @(negedge clk);
    chk("mixed_second_ch0", 32'(req_ready), 32'h1);
    chk("mixed_ch3_on_bank", 32'({bank_en[7], bank_we[7]}), 32'h2);
    step();
    drop_all();
    @(negedge clk);
    chk("mixed_ch0_write", 32'({bank_en[7], bank_we[7], bank_wdata[7*7 +: 7]}), 32'({2'b11, 7'h33}));

    // Reset mid-flight: ch1 read on bank 9 granted, reset asserted next cycle.
    step();
    drive(1, 1'b1, 1'b0, 9'h019, 7'h00);
    @(negedge clk);
    chk("midflight_ready", 32'(req_ready), 32'h2);
    step();
    drop_all();
    rst_n = 1'b0;
    #1;
    chk("midflight_bank_en", 32'(bank_en), 32'd0);
    chk("midflight_bank_we", 32'(bank_we), 32'd0);
    chk("midflight_bank_wdata", 32'(|bank_wdata), 32'd0);
    chk("midflight_bank_addr", 32'(|bank_addr), 32'd0);
    chk("midflight_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    for (int c = 0; c < 4; c++) drive(c, 1'b1, 1'b0, 9'h029, 7'h00);
    @(negedge clk);
    chk("restart_grant_ch0", 32'(req_ready), 32'h1);
    exp_q[0].push_back(7'h19);
    step();
    drop_all();

    repeat (8) step();
    for (int c = 0; c < 4; c++) chk($sformatf("pending_rsp_ch%0d", c), 32'(exp_q[c].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
